c_reverse_arb: RTL

Shared bit-order conversion unit for router datapaths. Multiple requesters (e.g. input-port flit-formatting logic) contend for one registered bit-reversal datapath. A round-robin arbiter grants at most one requester per cycle. The granted word is optionally reversed (bit i to bit width-1-i) and captured into a single-entry output register with a valid/ready handshake.

---
 rtl/c_reverse_arb_pkg.sv | 22 ++
 rtl/c_rr_pick.sv | 33 +++
 rtl/c_reverse_arb.sv | 94 +++++++++
 3 files changed

// File: rtl/c_reverse_arb_pkg.sv
// Shared helpers for the reverse arbiter slice: index-width math used by the
// picker and the top to size pointer and port-index fields.
package c_reverse_arb_pkg;

   function automatic int c_clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result++;
         v = v >> 1;
      end
      return result;
   endfunction

   // A single requester still needs a 1-bit index field.
   function automatic int c_idx_width(input int n);
      return (c_clog2(n) < 1) ? 1 : c_clog2(n);
   endfunction

endpackage

// File: rtl/c_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo num_ports. Returns one-hot and encoded grant.
module c_rr_pick
   import c_reverse_arb_pkg::*;
#(
   parameter  int num_ports      = 4,
   localparam int port_idx_width = c_idx_width(num_ports)
)(
   input  logic [0:num_ports-1]      req,
   input  logic [0:port_idx_width-1] ptr,
   output logic [0:num_ports-1]      gnt,
   output logic [0:port_idx_width-1] gnt_idx,
   output logic                      gnt_any
);

   always_comb begin
      int idx;
      idx     = 0;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int k = 0; k < num_ports; k++) begin
         idx = int'(ptr) + k;
         if (idx >= num_ports) idx = idx - num_ports;
         if (!gnt_any && req[idx]) begin
            gnt_any      = 1'b1;
            gnt[idx]     = 1'b1;
            gnt_idx      = port_idx_width'(idx);
         end
      end
   end

endmodule

// File: rtl/c_reverse_arb.sv
// Shared bit-reversal datapath: round-robin arbitration among requesters,
// optional bit reversal, single-entry output register with valid/ready.
module c_reverse_arb
   import c_reverse_arb_pkg::*;
#(
   parameter  int width          = 32,
   parameter  int num_ports      = 4,
   localparam int port_idx_width = c_idx_width(num_ports)
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic [0:num_ports-1]        req_valid,
   input  logic [0:num_ports-1]        req_rev,
   input  logic [0:num_ports*width-1]  req_data,
   output logic [0:num_ports-1]        req_ready,
   output logic                        out_valid,
   output logic [0:width-1]            out_data,
   output logic [0:port_idx_width-1]   out_port,
   input  logic                        out_ready
);

   localparam logic [0:port_idx_width-1] LAST_IDX = port_idx_width'(num_ports - 1);
   localparam logic [0:port_idx_width-1] ONE_IDX  = port_idx_width'(1);

   logic                      r_out_valid;
   logic [0:width-1]          r_out_data;
   logic [0:port_idx_width-1] r_out_port;
   logic [0:port_idx_width-1] r_ptr;

   logic                      w_accept;
   logic                      w_grant;
   logic [0:num_ports-1]      w_gnt;
   logic [0:port_idx_width-1] w_gnt_idx;
   logic                      w_gnt_any;
   logic [0:width-1]          w_sel_word;
   logic                      w_sel_rev;
   logic [0:width-1]          w_rev_word;
   logic [0:width-1]          w_next_word;

   // Drain and refill in the same cycle so continuous traffic has no bubble.
   assign w_accept = !r_out_valid || out_ready;

   c_rr_pick #(
      .num_ports (num_ports)
   ) u_pick (
      .req     (req_valid),
      .ptr     (r_ptr),
      .gnt     (w_gnt),
      .gnt_idx (w_gnt_idx),
      .gnt_any (w_gnt_any)
   );

   assign w_grant   = w_accept && w_gnt_any && !reset;
   assign req_ready = w_grant ? w_gnt : '0;

   always_comb begin
      w_sel_word = '0;
      w_sel_rev  = 1'b0;
      for (int p = 0; p < num_ports; p++) begin
         if (w_gnt[p]) begin
            w_sel_word = req_data[p*width +: width];
            w_sel_rev  = req_rev[p];
         end
      end
   end

   for (genvar i = 0; i < width; i++) begin : g_rev
      assign w_rev_word[i] = w_sel_word[width-1-i];
   end

   assign w_next_word = w_sel_rev ? w_rev_word : w_sel_word;

   // Priority only rotates on a real grant; idle and stall cycles keep it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_port  <= '0;
         r_ptr       <= '0;
      end else if (w_grant) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_next_word;
         r_out_port  <= w_gnt_idx;
         r_ptr       <= (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + ONE_IDX;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_port  = r_out_port;

endmodule
